score_keeper: RTL and testbench

Parametrised Connect-4 scoreboard: keeps one BCD score per player, counts rising edges of per-player increment/decrement request lines, and flags the first player(s) to reach a target score. Sits between the game-control FSM (which raises a player line when a round is won or undone) and the seven-segment display driver, which consumes the packed BCD digits directly. Generalises the fixed two-player, two-digit, wrap-at-99 counter with configurable player count, digit count and overflow mode, plus decrement, clear, win detection and game-over lockout.

---
 rtl/score_keeper_if.sv | 23 ++
 rtl/score_keeper.sv | 132 +++++++++++++
 tb/tb_score_keeper.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Request/score bundle between the game-control FSM, the scoreboard and the display driver.
interface score_keeper_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2
);
    logic [NUM_PLAYERS-1:0]          inc;
    logic [NUM_PLAYERS-1:0]          dec;
    logic                            clr;
    logic [NUM_PLAYERS*DIGITS*4-1:0] score;
    logic [NUM_PLAYERS-1:0]          win;
    logic                            game_over;
    logic [NUM_PLAYERS-1:0]          overflow;

    modport master (
        output inc, dec, clr,
        input  score, win, game_over, overflow
    );

    modport slave (
        input  inc, dec, clr,
        output score, win, game_over, overflow
    );
endinterface

// File: rtl/score_keeper.sv
// Multi-player BCD scoreboard: edge-counted inc/dec requests, optional saturation,
// sticky win detection and increment lockout once any player has won.
module score_keeper #(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2,
    parameter int SATURATE    = 0,
    parameter int WIN_SCORE   = 10
) (
    input logic           clk,
    input logic           reset,
    score_keeper_if.slave bus
);
    localparam int SW = DIGITS * 4;
    typedef logic [SW-1:0] bcd_t;

    function automatic bcd_t to_bcd(input int unsigned value);
        bcd_t        r;
        int unsigned v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < unsigned'(DIGITS); i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    function automatic bcd_t bcd_inc(input bcd_t value);
        bcd_t r;
        logic carry;
        r     = value;
        carry = 1'b1;
        for (int unsigned i = 0; i < unsigned'(DIGITS); i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic bcd_t bcd_dec(input bcd_t value);
        bcd_t r;
        logic borrow;
        r      = value;
        borrow = 1'b1;
        for (int unsigned i = 0; i < unsigned'(DIGITS); i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam bcd_t MAX_BCD = to_bcd(unsigned'(10**DIGITS - 1));
    localparam bcd_t WIN_BCD = to_bcd(unsigned'(WIN_SCORE));

    logic [NUM_PLAYERS-1:0]    inc_s, inc_h, dec_s, dec_h;
    logic [NUM_PLAYERS-1:0]    inc_e, dec_e;
    logic [NUM_PLAYERS-1:0]    win_q, win_d;
    logic [NUM_PLAYERS-1:0]    ovf_q, ovf_d;
    logic [NUM_PLAYERS*SW-1:0] score_q, score_d;
    logic                      game_over;

    assign inc_e     = inc_s & ~inc_h;
    assign dec_e     = dec_s & ~dec_h;
    assign game_over = |win_q;

    always_comb begin
        score_d = score_q;
        win_d   = win_q;
        ovf_d   = '0;
        if (bus.clr) begin
            score_d = '0;
            win_d   = '0;
        end else begin
            for (int unsigned p = 0; p < unsigned'(NUM_PLAYERS); p++) begin
                // Simultaneous inc and dec edges cancel: neither branch fires.
                if (inc_e[p] && !dec_e[p] && !game_over) begin
                    if (score_q[p*SW +: SW] == MAX_BCD) begin
                        ovf_d[p] = 1'b1;
                        if (SATURATE == 0) begin
                            score_d[p*SW +: SW] = '0;
                        end
                    end else begin
                        score_d[p*SW +: SW] = bcd_inc(score_q[p*SW +: SW]);
                    end
                    if (WIN_SCORE != 0 && score_d[p*SW +: SW] == WIN_BCD) begin
                        win_d[p] = 1'b1;
                    end
                end else if (dec_e[p] && !inc_e[p] && score_q[p*SW +: SW] != '0) begin
                    score_d[p*SW +: SW] = bcd_dec(score_q[p*SW +: SW]);
                end
            end
        end
    end

    // Sync and history both start high so a line held across reset release is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_s   <= '1;
            inc_h   <= '1;
            dec_s   <= '1;
            dec_h   <= '1;
            score_q <= '0;
            win_q   <= '0;
            ovf_q   <= '0;
        end else begin
            inc_s   <= bus.inc;
            inc_h   <= inc_s;
            dec_s   <= bus.dec;
            dec_h   <= dec_s;
            score_q <= score_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.score     = score_q;
    assign bus.win       = win_q;
    assign bus.game_over = game_over;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper against an integer-score reference model.
module tb_score_keeper;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0] inc_v, dec_v;
    logic       clr_v;

    score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(2)) if_a ();
    score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(2)) if_b ();
    score_keeper_if #(.NUM_PLAYERS(3), .DIGITS(2)) if_c ();

    assign if_a.inc = inc_v[1:0];
    assign if_a.dec = dec_v[1:0];
    assign if_a.clr = clr_v;
    assign if_b.inc = inc_v[1:0];
    assign if_b.dec = dec_v[1:0];
    assign if_b.clr = clr_v;
    assign if_c.inc = inc_v;
    assign if_c.dec = dec_v;
    assign if_c.clr = clr_v;

    score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .SATURATE(0), .WIN_SCORE(10)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .SATURATE(0), .WIN_SCORE(0)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));
    score_keeper #(.NUM_PLAYERS(3), .DIGITS(2), .SATURATE(1), .WIN_SCORE(0)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer scores per instance, requests seen one edge later.
    int         np[3]  = '{2, 2, 3};
    int         sat[3] = '{0, 0, 1};
    int         wsc[3] = '{10, 0, 0};
    int         sc[3][3];
    logic [2:0] winm[3];
    logic [2:0] ovfm[3];
    logic [2:0] prev_i, prev_d, pend_i, pend_d;

    function automatic logic [31:0] packed_score(input int k);
        logic [31:0] r;
        r = '0;
        for (int p = 0; p < np[k]; p++) begin
            r[p*8 +: 8] = {4'(sc[k][p] / 10), 4'(sc[k][p] % 10)};
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 3; p++) sc[k][p] = 0;
            winm[k] = '0;
            ovfm[k] = '0;
        end
        prev_i = '1;
        prev_d = '1;
        pend_i = '0;
        pend_d = '0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            logic go;
            go      = |winm[k];
            ovfm[k] = '0;
            if (clr_v) begin
                for (int p = 0; p < 3; p++) sc[k][p] = 0;
                winm[k] = '0;
            end else begin
                for (int p = 0; p < np[k]; p++) begin
                    if (pend_i[p] && pend_d[p]) begin
                    end else if (pend_i[p]) begin
                        if (!go) begin
                            if (sc[k][p] == 99) begin
                                ovfm[k][p] = 1'b1;
                                if (sat[k] == 0) sc[k][p] = 0;
                            end else begin
                                sc[k][p]++;
                            end
                            if (wsc[k] != 0 && sc[k][p] == wsc[k]) winm[k][p] = 1'b1;
                        end
                    end else if (pend_d[p] && sc[k][p] > 0) begin
                        sc[k][p]--;
                    end
                end
            end
        end
        pend_i = inc_v & ~prev_i;
        pend_d = dec_v & ~prev_d;
        prev_i = inc_v;
        prev_d = dec_v;
    endtask

    task automatic compare_all();
        check("A.score", 32'(if_a.score), packed_score(0));
        check("A.win", 32'(if_a.win), 32'(winm[0][1:0]));
        check("A.game_over", 32'(if_a.game_over), 32'(|winm[0]));
        check("A.overflow", 32'(if_a.overflow), 32'(ovfm[0][1:0]));
        check("B.score", 32'(if_b.score), packed_score(1));
        check("B.win", 32'(if_b.win), 32'(winm[1][1:0]));
        check("B.overflow", 32'(if_b.overflow), 32'(ovfm[1][1:0]));
        check("C.score", 32'(if_c.score), packed_score(2));
        check("C.overflow", 32'(if_c.overflow), 32'(ovfm[2]));
        check("C.game_over", 32'(if_c.game_over), 32'(|winm[2]));
    endtask

    task automatic cyc(input logic [2:0] i, input logic [2:0] d, input logic c);
        inc_v = i;
        dec_v = d;
        clr_v = c;
        @(posedge clk);
        model_edge();
        #1 compare_all();
    endtask

    task automatic pulse(input logic [2:0] i, input logic [2:0] d);
        cyc(i, d, 1'b0);
        cyc(3'b000, 3'b000, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        inc_v = 3'b001;
        dec_v = 3'b000;
        clr_v = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst.A.score", 32'(if_a.score), 32'h0);
        check("rst.A.win", 32'(if_a.win), 32'h0);
        check("rst.C.overflow", 32'(if_c.overflow), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Held across reset release: no count; then fall/rise gives one count after two edges.
        repeat (4) cyc(3'b001, 3'b000, 1'b0);
        check("hold.A.score", 32'(if_a.score), 32'h0);
        cyc(3'b000, 3'b000, 1'b0);
        cyc(3'b001, 3'b000, 1'b0);
        check("lat1.A.score", 32'(if_a.score), 32'h0);
        cyc(3'b001, 3'b000, 1'b0);
        check("lat2.A.score", 32'(if_a.score), 32'h0001);
        cyc(3'b000, 3'b000, 1'b0);
        cyc(3'b000, 3'b000, 1'b1);

        // Wrap (B) and saturate (C) on player 1.
        for (int n = 1; n <= 100; n++) begin
            pulse(3'b010, 3'b000);
            if (n == 99) check("wrap99.B", 32'(if_b.score[15:8]), 32'h99);
        end
        check("wrap100.B", 32'(if_b.score[15:8]), 32'h00);
        check("wrap100.B.ovf", 32'(if_b.overflow), 32'h2);
        check("sat100.C", 32'(if_c.score[15:8]), 32'h99);
        check("sat100.C.ovf", 32'(if_c.overflow), 32'h2);
        cyc(3'b000, 3'b000, 1'b0);
        check("ovf_once.B", 32'(if_b.overflow), 32'h0);
        cyc(3'b000, 3'b000, 1'b1);

        // Simultaneous win by both players on A, then lockout.
        repeat (9) pulse(3'b011, 3'b000);
        check("win09.A", 32'(if_a.score), 32'h0909);
        pulse(3'b011, 3'b000);
        check("win10.A", 32'(if_a.score), 32'h1010);
        check("win.A", 32'(if_a.win), 32'h3);
        check("go.A", 32'(if_a.game_over), 32'h1);
        pulse(3'b011, 3'b000);
        check("lock.A", 32'(if_a.score), 32'h1010);

        // Decrement cases.
        cyc(3'b000, 3'b000, 1'b1);
        repeat (5) pulse(3'b001, 3'b000);
        pulse(3'b001, 3'b001);
        check("incdec.A", 32'(if_a.score[7:0]), 32'h05);
        repeat (5) pulse(3'b000, 3'b001);
        pulse(3'b000, 3'b001);
        check("dec0.A", 32'(if_a.score[7:0]), 32'h00);
        repeat (10) pulse(3'b001, 3'b000);
        pulse(3'b000, 3'b001);
        check("dec10.A", 32'(if_a.score[7:0]), 32'h09);
        check("dec_keeps_win.A", 32'(if_a.win), 32'h1);

        // clr in the cycle an inc edge is detected discards that edge.
        cyc(3'b000, 3'b000, 1'b0);
        cyc(3'b001, 3'b000, 1'b0);
        cyc(3'b001, 3'b000, 1'b1);
        check("clr.A.score", 32'(if_a.score), 32'h0);
        check("clr.A.win", 32'(if_a.win), 32'h0);
        check("clr.A.go", 32'(if_a.game_over), 32'h0);
        repeat (2) cyc(3'b001, 3'b000, 1'b0);
        check("clr_discard.A", 32'(if_a.score), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            cyc(3'($urandom), 3'($urandom & $urandom), ($urandom_range(0, 63) == 0));
            if (n == 1500) begin
                #2 reset = 1'b0;
                #1;
                check("async.A.score", 32'(if_a.score), 32'h0);
                check("async.A.win", 32'(if_a.win), 32'h0);
                check("async.B.score", 32'(if_b.score), 32'h0);
                check("async.C.score", 32'(if_c.score), 32'h0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
                model_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
